// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters/FIFO write handler and the write arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic                   wfull;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic                   wr_en;
  logic [DWIDTH-1:0]      wr_data;
  logic                   busy;

  modport master (
    output req, req_data, wfull,
    input  gnt, ack, wr_en, wr_data, busy
  );

  modport slave (
    input  req, req_data, wfull,
    output gnt, ack, wr_en, wr_data, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters in bursts of up to
// MAXBURST words, stalling while the FIFO reports full.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned MAXBURST = 4
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e          r_state, w_state_d;
  logic [IW-1:0]   r_owner, w_owner_d;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr_d;
  logic [BW-1:0]   r_bcnt, w_bcnt_d;

  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic [IW:0]     w_sum;
  logic [IW-1:0]   w_owner_inc;
  logic [NREQ-1:0] w_onehot;
  logic [DWIDTH-1:0] w_data_sel;
  logic            w_write;

  // Circular priority scan starting at rr_ptr; the wrap is explicit so any NREQ works.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end
      if (!w_found && bus.req[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_data_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IW'(i) == r_owner) begin
        w_data_sel = bus.req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign w_owner_inc = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_onehot    = NREQ'(1) << r_owner;
  assign w_write     = (r_state == StBurst) && bus.req[r_owner] && !bus.wfull;

  always_comb begin
    w_state_d  = r_state;
    w_owner_d  = r_owner;
    w_rr_ptr_d = r_rr_ptr;
    w_bcnt_d   = r_bcnt;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StBurst;
          w_owner_d = w_sel;
          w_bcnt_d  = '0;
        end
      end
      StBurst: begin
        if (!bus.req[r_owner]) begin
          w_state_d  = StIdle;
          w_rr_ptr_d = w_owner_inc;
        end else if (!bus.wfull) begin
          if (r_bcnt == BW'(MAXBURST - 1)) begin
            w_state_d  = StIdle;
            w_rr_ptr_d = w_owner_inc;
          end else begin
            w_bcnt_d = r_bcnt + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_state  <= StIdle;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_bcnt   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_owner  <= w_owner_d;
      r_rr_ptr <= w_rr_ptr_d;
      r_bcnt   <= w_bcnt_d;
    end
  end

  // Outputs decode registered state, so an asynchronous reset drops them at once.
  assign bus.busy    = (r_state == StBurst);
  assign bus.gnt     = bus.busy ? w_onehot : '0;
  assign bus.ack     = w_write ? w_onehot : '0;
  assign bus.wr_en   = w_write;
  assign bus.wr_data = w_write ? w_data_sel : '0;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO write domain. It shares the single FIFO write port among NREQ requesters, grants bounded bursts of up to MAXBURST words, and stalls on the FIFO full flag. It sits in front of the write-pointer handler on wr_clk: it produces wr_en/wr_data toward the FIFO and consumes wfull from it.

## Interface
- NREQ, 4, number of requesters (≥2)
- DWIDTH, 8, data word width
- MAXBURST, 4, maximum words written per grant (≥1)
- wr_clk  in  1  write-domain clock
- wr_rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester write request; held high while a word is offered
- req_data  in  NREQ*DWIDTH  flattened data; requester i occupies bits [i*DWIDTH +: DWIDTH]
- wfull  in  1  FIFO full flag from the write handler
- gnt  out  NREQ  one-hot current burst owner, registered
- ack  out  NREQ  one-hot; word from requester i consumed this cycle
- wr_en  out  1  FIFO write enable
- wr_data  out  DWIDTH  FIFO write data
- busy  out  1  high in BURST state

## Operation
- The state machine has two states: IDLE and BURST. Registers are state, owner ($clog2(NREQ) bits), rr_ptr ($clog2(NREQ) bits), and bcnt ($clog2(MAXBURST), minimum 1 bit).
- IDLE: if any req bit is high, select the first asserted index scanning circularly from rr_ptr upward. On the next edge, owner takes the selected index, bcnt clears to 0, and state moves to BURST. If no req bit is high, stay in IDLE.
- BURST: gnt equals the one-hot decode of owner. busy is 1.
- The write condition is w = BURST && req[owner] && !wfull. It is combinational from registered state and the live inputs.
- When w is true: wr_en=1, ack[owner]=1, and wr_data=req_data[owner slice].
- When w is false: wr_en=0, ack=0, and wr_data=0.
- On a write with bcnt==MAXBURST-1, the burst ends: next state is IDLE and rr_ptr becomes owner+1 mod NREQ.
- On a write with bcnt<MAXBURST-1, bcnt increments and the block stays in BURST.
- When req[owner]==0 in BURST, the burst ends on that edge: no write that cycle, next state is IDLE, and rr_ptr becomes owner+1 mod NREQ.
- When req[owner]==1 and wfull==1, the block stalls: it stays in BURST, bcnt holds, and ack stays 0. There is no timeout.
- Requests from non-owners are ignored during BURST. They see gnt and ack low.
- rr_ptr advances only at burst end. This guarantees every persistent requester is granted within NREQ-1 bursts.

## Timing
- Reset values: state=IDLE, owner=0, rr_ptr=0, bcnt=0, gnt=0, ack=0, wr_en=0, wr_data=0, busy=0.
- Reset is asynchronous. Asserting wr_rst mid-burst clears gnt and busy immediately, which forces wr_en=0. The partial burst is abandoned.
- Grant latency: req rising in cycle N while IDLE gives gnt and busy high in cycle N+1. The first wr_en is possible in N+1.
- There is one IDLE bubble cycle between consecutive bursts. Sustained throughput is MAXBURST/(MAXBURST+1) words per cycle.
- A word is transferred exactly on a wr_clk edge where ack[i]=1. The requester presents the next word or drops req in the following cycle.
- wfull rising and falling takes effect in the same cycle through the combinational w. No word is lost or duplicated.
- If wfull and the end of a burst coincide (owner's last word, wfull=1), the block waits. The burst ends only after the final word is written or req drops.
- MAXBURST=1: every write ends the burst.
- NREQ a non-power-of-2: rr_ptr wraps from NREQ-1 to 0 explicitly.

## Test plan
- Single requester: req[2]=1 held, data 0x10..0x17, wfull=0.
  - Expect gnt=4'b0100 from cycle 1.
  - Expect 4 writes 0x10–0x13, then a 1-cycle IDLE gap, then 0x14–0x17.
- Round-robin: req=4'b1111 held.
  - Expect owner sequence 0,1,2,3,0 with 4 writes each.
  - Expect wr_en high for 16 of the 20 cycles after the first grant.
- Early release: req[1] drops after 2 acks.
  - Expect the burst to end after 2 words, busy low the next cycle, and rr_ptr=2.
- Full stall: wfull=1 for 5 cycles mid-burst after word 2.
  - Expect wr_en=0 and ack=0 during the stall, and bcnt to hold.
  - Expect words 3–4 written after wfull falls, with no duplicates (check the FIFO model).
- Reset mid-burst: assert wr_rst asynchronously between edges during a write.
  - Expect gnt=0 and wr_en=0 immediately.
  - After release, expect arbitration to restart from requester 0.
- Fairness: req[0] held continuously, req[3] asserted once.
  - Expect req[3] granted right after the current owner-0 burst.
  - Expect owner 0 not to be granted twice in a row while req[3] is pending.
